// File: rtl/mem_stage_pl_if.sv
// mem_stage_pl_if: EX/MEM request bundle and MEM result bundle for mem_stage_pl.
// Requests: valid_in, mem_addr, wr_data, mem_wr, mem_rd, br_valid, branch_op, flags {N,Z,V}.
// Results: stall, rd_data, rd_valid, pc_src, addr_err.
interface mem_stage_pl_if #(
  parameter int DW = 16,
  parameter int AW = 16
);
  logic          valid_in;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] wr_data;
  logic          mem_wr;
  logic          mem_rd;
  logic          br_valid;
  logic [2:0]    branch_op;
  logic [2:0]    flags;
  logic          stall;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          pc_src;
  logic          addr_err;
  modport master (
    output valid_in, mem_addr, wr_data, mem_wr, mem_rd, br_valid, branch_op, flags,
    input  stall, rd_data, rd_valid, pc_src, addr_err
  );
  modport slave (
    input  valid_in, mem_addr, wr_data, mem_wr, mem_rd, br_valid, branch_op, flags,
    output stall, rd_data, rd_valid, pc_src, addr_err
  );
endinterface

// File: rtl/mem_stage_pl.sv
// mem_stage_pl: MEM stage with a DEPTH-word data memory, RD_LAT-cycle loads with stall,
// branch resolution from {N,Z,V} and a one-cycle illegal-access pulse.
// Ports: clk; rst_n (async, active low); bus (slave modport of mem_stage_pl_if):
// request side in, stall/rd_data/rd_valid/pc_src/addr_err out.
module mem_stage_pl #(
  parameter int DW     = 16,
  parameter int AW     = 16,
  parameter int DEPTH  = 1024,
  parameter int RD_LAT = 2
) (
  input logic           clk,
  input logic           rst_n,
  mem_stage_pl_if.slave bus
);
  localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] LIMIT = (AW + 1)'(DEPTH);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t        state_q, state_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [IW-1:0] addr_q, addr_d;
  logic [DW-1:0] rd_data_q, rd_data_d;
  logic          rd_valid_q, rd_valid_d;
  logic          addr_err_q, addr_err_d;
  logic [DW-1:0] mem [DEPTH];
  logic          accept, bad, do_wr, do_rd, active, done;
  logic [IW-1:0] rd_idx;
  logic          n, z, v;
  logic [7:0]    taken;
  assign {n, z, v} = bus.flags;
  // one bit per condition code, indexed by branch_op
  assign taken = {1'b1, v, n | z, !n, n, !z & !n, z, !z};
  always_comb begin
    accept     = state_q == IDLE && bus.valid_in;
    bad        = (bus.mem_rd && bus.mem_wr) ||
                 ((bus.mem_rd || bus.mem_wr) && {1'b0, bus.mem_addr} >= LIMIT);
    do_wr      = accept && bus.mem_wr && !bad;
    do_rd      = accept && bus.mem_rd && !bad;
    rd_idx     = state_q == IDLE ? bus.mem_addr[IW-1:0] : addr_q;
    active     = do_rd || state_q == BUSY;
    cnt_d      = do_rd ? 3'(RD_LAT - 1) : state_q == BUSY ? cnt_q - 3'd1 : cnt_q;
    // RD_LAT=1 completes on the accepting edge, so BUSY is never entered
    done       = active && cnt_d == 3'd0;
    state_d    = active && !done ? BUSY : IDLE;
    addr_d     = do_rd ? rd_idx : addr_q;
    rd_data_d  = done ? mem[rd_idx] : rd_data_q;
    rd_valid_d = done;
    addr_err_d = accept && bad;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      addr_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      addr_err_q <= addr_err_d;
    end
  always_ff @(posedge clk)
    if (do_wr) mem[rd_idx] <= bus.wr_data;
  assign bus.stall    = state_q == BUSY;
  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.addr_err = addr_err_q;
  assign bus.pc_src   = bus.valid_in && bus.br_valid && state_q != BUSY && taken[bus.branch_op];
endmodule

// File: tb/tb_mem_stage_pl.sv
// tb_mem_stage_pl: three mem_stage_pl instances (RD_LAT 1, 2, 4) against a behavioural model.
module tb_mem_stage_pl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  logic [2:0]       vin = '0, wr_i = '0, rd_i = '0, bv_i = '0;
  logic [2:0][15:0] addr_i = '0, wd_i = '0;
  logic [2:0][2:0]  op_i = '0, fl_i = '0;
  logic [2:0]       stall_o, rdv_o, pc_o, err_o;
  logic [2:0][15:0] rdd_o;
  logic [2:0]       xp_stall, xp_rv, xp_err;
  logic [2:0][15:0] xp_rd;
  int total = 0, passed = 0;
  function automatic logic br_taken(logic [2:0] op, logic [2:0] f);
    logic n, z, v;
    n = f[2];
    z = f[1];
    v = f[0];
    case (op)
      3'd0: return !z;
      3'd1: return z;
      3'd2: return !z && !n;
      3'd3: return n;
      3'd4: return !n;
      3'd5: return n || z;
      3'd6: return v;
      default: return 1'b1;
    endcase
  endfunction
  for (genvar g = 0; g < 3; g++) begin : inst
    localparam int L = g == 0 ? 1 : g == 1 ? 2 : 4;
    mem_stage_pl_if #(.DW(16), .AW(16)) bus ();
    assign bus.valid_in  = vin[g];
    assign bus.mem_addr  = addr_i[g];
    assign bus.wr_data   = wd_i[g];
    assign bus.mem_wr    = wr_i[g];
    assign bus.mem_rd    = rd_i[g];
    assign bus.br_valid  = bv_i[g];
    assign bus.branch_op = op_i[g];
    assign bus.flags     = fl_i[g];
    assign stall_o[g]    = bus.stall;
    assign rdd_o[g]      = bus.rd_data;
    assign rdv_o[g]      = bus.rd_valid;
    assign pc_o[g]       = bus.pc_src;
    assign err_o[g]      = bus.addr_err;
    mem_stage_pl #(.DW(16), .AW(16), .DEPTH(1024), .RD_LAT(L)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus.slave)
    );
    // model: a load is in flight until edge number done_at, then its value appears
    logic [15:0] mem_m [1024];
    logic        pend = 1'b0, e_rv = 1'b0, e_err = 1'b0;
    logic [15:0] e_rd = '0, ld_val = '0;
    int          t = 0, done_at = 0;
    always @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        pend  <= 1'b0;
        e_rv  <= 1'b0;
        e_err <= 1'b0;
        e_rd  <= '0;
      end else begin
        t     <= t + 1;
        e_rv  <= 1'b0;
        e_err <= 1'b0;
        if (pend) begin
          if (t == done_at) begin
            e_rv <= 1'b1;
            e_rd <= ld_val;
            pend <= 1'b0;
          end
        end else if (vin[g]) begin
          if ((rd_i[g] && wr_i[g]) || ((rd_i[g] || wr_i[g]) && addr_i[g] >= 16'd1024))
            e_err <= 1'b1;
          else if (wr_i[g])
            mem_m[addr_i[g][9:0]] <= wd_i[g];
          else if (rd_i[g]) begin
            if (L == 1) begin
              e_rv <= 1'b1;
              e_rd <= mem_m[addr_i[g][9:0]];
            end else begin
              pend    <= 1'b1;
              done_at <= t + L - 1;
              ld_val  <= mem_m[addr_i[g][9:0]];
            end
          end
        end
      end
    assign xp_stall[g] = pend;
    assign xp_rv[g]    = e_rv;
    assign xp_err[g]   = e_err;
    assign xp_rd[g]    = e_rd;
  end
  task automatic check(string name, int k, logic [15:0] act, logic [15:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s inst%0d: got %h expected %h at %0t", name, k, act, exp, $time);
  endtask
  always @(negedge clk)
    if (rst_n)
      for (int k = 0; k < 3; k++) begin
        check("stall", k, 16'(stall_o[k]), 16'(xp_stall[k]));
        check("rd_valid", k, 16'(rdv_o[k]), 16'(xp_rv[k]));
        check("addr_err", k, 16'(err_o[k]), 16'(xp_err[k]));
        check("rd_data", k, rdd_o[k], xp_rd[k]);
        check("pc_src", k, 16'(pc_o[k]),
              16'(vin[k] && bv_i[k] && !xp_stall[k] && br_taken(op_i[k], fl_i[k])));
      end
  task automatic put_all(logic v, logic [15:0] a, logic [15:0] d, logic w, logic r,
                         logic b, logic [2:0] op, logic [2:0] f);
    for (int k = 0; k < 3; k++) begin
      vin[k] = v; addr_i[k] = a; wd_i[k] = d; wr_i[k] = w; rd_i[k] = r;
      bv_i[k] = b; op_i[k] = op; fl_i[k] = f;
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  int rv_n[3], rv_at[3], st_n[3], er_n[3], er_at[3];
  logic [15:0] rv_d0[3], rv_d1[3];
  task automatic observe(int n);
    for (int k = 0; k < 3; k++) begin
      rv_n[k] = 0; rv_at[k] = -1; st_n[k] = 0; er_n[k] = 0; er_at[k] = -1;
      rv_d0[k] = '0; rv_d1[k] = '0;
    end
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        if (stall_o[k]) st_n[k]++;
        if (err_o[k]) begin
          if (er_n[k] == 0) er_at[k] = i;
          er_n[k]++;
        end
        if (rdv_o[k]) begin
          if (rv_n[k] == 0) begin rv_at[k] = i; rv_d0[k] = rdd_o[k]; end
          if (rv_n[k] == 1) rv_d1[k] = rdd_o[k];
          rv_n[k]++;
        end
      end
      step();
      put_all(0, 0, 0, 0, 0, 0, 0, 0);
    end
  endtask
  task automatic rnd(int k);
    int c, s;
    c = $urandom_range(0, 9);
    s = $urandom_range(0, 9);
    addr_i[k] = s < 6 ? 16'($urandom_range(0, 31)) : s < 8 ? 16'($urandom_range(1016, 1023)) :
                s == 8 ? 16'h0400 : 16'($urandom_range(1024, 65535));
    vin[k]  = $urandom_range(0, 4) != 0;
    wd_i[k] = 16'($urandom);
    wr_i[k] = c < 3 || c == 6;
    rd_i[k] = (c >= 3 && c < 6) || c == 6;
    bv_i[k] = !rd_i[k] && $urandom_range(0, 1) == 1;
    op_i[k] = 3'($urandom_range(0, 7));
    fl_i[k] = 3'($urandom_range(0, 7));
  endtask
  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check("reset_stall", k, 16'(stall_o[k]), 16'h0);
      check("reset_rd_valid", k, 16'(rdv_o[k]), 16'h0);
      check("reset_addr_err", k, 16'(err_o[k]), 16'h0);
      check("reset_rd_data", k, rdd_o[k], 16'h0);
    end
    #2 rst_n = 1'b1;
    step();
    for (int a = 0; a < 32; a++) begin put_all(1, 16'(a), 16'(a) ^ 16'h5A5A, 1, 0, 0, 0, 0); step(); end
    for (int a = 1016; a < 1024; a++) begin put_all(1, 16'(a), 16'(a) ^ 16'h5A5A, 1, 0, 0, 0, 0); step(); end
    put_all(1, 16'd3, 16'h1111, 1, 0, 0, 0, 0); step();
    put_all(1, 16'd4, 16'h2222, 1, 0, 0, 0, 0); step();
    put_all(1, 16'd5, 16'hBEEF, 1, 0, 0, 0, 0); step();
    put_all(1, 16'd5, 0, 0, 1, 0, 0, 0);
    observe(8);
    for (int k = 0; k < 3; k++) begin
      check("load_latency", k, 16'(rv_at[k]), k == 0 ? 16'd1 : k == 1 ? 16'd2 : 16'd4);
      check("load_stall_cycles", k, 16'(st_n[k]), k == 0 ? 16'd0 : k == 1 ? 16'd1 : 16'd3);
      check("load_data", k, rv_d0[k], 16'hBEEF);
      check("load_pulses", k, 16'(rv_n[k]), 16'd1);
    end
    put_all(1, 16'd3, 0, 0, 1, 0, 0, 0); step();
    put_all(1, 16'd4, 0, 0, 1, 0, 0, 0);
    observe(8);
    check("b2b_first", 0, rv_d0[0], 16'h1111);
    check("b2b_second", 0, rv_d1[0], 16'h2222);
    check("b2b_first_at", 0, 16'(rv_at[0]), 16'd0);
    check("b2b_pulses", 0, 16'(rv_n[0]), 16'd2);
    check("b2b_no_stall", 0, 16'(st_n[0]), 16'd0);
    check("busy_ignores", 1, rv_d0[1], 16'h1111);
    check("busy_pulses", 2, 16'(rv_n[2]), 16'd1);
    put_all(1, 16'h0400, 0, 0, 1, 0, 0, 0);
    observe(6);
    for (int k = 0; k < 3; k++) begin
      check("oob_load_err_at", k, 16'(er_at[k]), 16'd1);
      check("oob_load_err_len", k, 16'(er_n[k]), 16'd1);
      check("oob_load_no_rv", k, 16'(rv_n[k]), 16'd0);
      check("oob_load_no_stall", k, 16'(st_n[k]), 16'd0);
      check("oob_load_rd_data", k, rdd_o[k], k == 0 ? 16'h2222 : 16'h1111);
    end
    put_all(1, 16'hFFFF, 16'h1234, 1, 0, 0, 0, 0);
    observe(4);
    put_all(1, 16'h03FF, 0, 0, 1, 0, 0, 0);
    observe(8);
    for (int k = 0; k < 3; k++) check("oob_store_kept", k, rv_d0[k], 16'h59A5);
    put_all(1, 16'h0010, 16'hDEAD, 1, 1, 0, 0, 0);
    observe(4);
    for (int k = 0; k < 3; k++) begin
      check("rdwr_err_at", k, 16'(er_at[k]), 16'd1);
      check("rdwr_no_rv", k, 16'(rv_n[k]), 16'd0);
    end
    put_all(1, 16'h0010, 0, 0, 1, 0, 0, 0);
    observe(8);
    for (int k = 0; k < 3; k++) check("rdwr_kept", k, rv_d0[k], 16'h5A4A);
    put_all(1, 16'd7, 16'h7777, 1, 0, 0, 0, 0); step();
    put_all(1, 16'd7, 0, 0, 1, 0, 0, 0);
    observe(8);
    for (int k = 0; k < 3; k++) check("store_then_load", k, rv_d0[k], 16'h7777);
    for (int op = 0; op < 8; op++)
      for (int f = 0; f < 8; f++) begin
        put_all(1, 16'd1, 16'h0101, 1, 0, 1, 3'(op), 3'(f));
        step();
      end
    put_all(1, 0, 0, 0, 0, 1, 3'd2, 3'b000); @(negedge clk); check("bgt_000", 0, 16'(pc_o[0]), 16'd1); step();
    put_all(1, 0, 0, 0, 0, 1, 3'd2, 3'b010); @(negedge clk); check("bgt_010", 0, 16'(pc_o[0]), 16'd0); step();
    put_all(1, 0, 0, 0, 0, 1, 3'd6, 3'b001); @(negedge clk); check("bovfl_001", 0, 16'(pc_o[0]), 16'd1); step();
    put_all(1, 0, 0, 0, 0, 0, 3'd7, 3'b000); @(negedge clk); check("no_br_valid", 0, 16'(pc_o[0]), 16'd0); step();
    put_all(0, 0, 0, 0, 0, 1, 3'd7, 3'b000); @(negedge clk); check("no_valid_in", 0, 16'(pc_o[0]), 16'd0); step();
    put_all(1, 16'd5, 0, 0, 1, 0, 0, 0); step();
    put_all(0, 0, 0, 0, 0, 0, 0, 0); step();
    check("busy_before_reset", 2, 16'(stall_o[2]), 16'd1);
    #2 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      check("abort_stall", k, 16'(stall_o[k]), 16'd0);
      check("abort_rd_data", k, rdd_o[k], 16'h0);
    end
    @(negedge clk);
    #2 rst_n = 1'b1;
    step();
    observe(8);
    for (int k = 0; k < 3; k++) check("abort_no_rv", k, 16'(rv_n[k]), 16'd0);
    put_all(1, 16'd5, 0, 0, 1, 0, 0, 0);
    observe(8);
    for (int k = 0; k < 3; k++) check("mem_survives_reset", k, rv_d0[k], 16'hBEEF);
    for (int i = 0; i < 3000; i++) begin
      step();
      for (int k = 0; k < 3; k++) if (!stall_o[k]) rnd(k);
    end
    put_all(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (10) step();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/mem_stage_pl.md
Name: mem_stage_pl

Overview:
- Parametrised next-generation memory stage for the pipelined core.
- Sits between EX and WB. Holds word-addressed data memory of DEPTH entries with configurable read latency and a stall handshake toward the pipeline.
- Resolves the eight branch conditions from the N/Z/V flags, qualified by instruction valid.
- Adds an address/command error indication.

Parameters:
- DW, 16, data word width in bits.
- AW, 16, address input width in bits.
- DEPTH, 1024, number of memory words; legal addresses are 0..DEPTH-1.
- RD_LAT, 2, read latency in cycles, from accepted read to rd_valid (legal range 1..8).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- valid_in  input  1  EX/MEM instruction valid; held stable by upstream while stall=1.
- mem_addr  input  AW  word address.
- wr_data  input  DW  store data.
- mem_wr  input  1  store request.
- mem_rd  input  1  load request.
- br_valid  input  1  instruction is a branch.
- branch_op  input  3  condition code: 000 BNEQ, 001 BEQ, 010 BGT, 011 BLT, 100 BGTE, 101 BLTE, 110 BOVFL, 111 BUNCOND.
- flags  input  3  {N,Z,V}.
- stall  output  1  load in progress; upstream must freeze.
- rd_data  output  DW  load result; held until next load completes.
- rd_valid  output  1  one-cycle pulse when rd_data is updated.
- pc_src  output  1  branch taken.
- addr_err  output  1  one-cycle pulse for an illegal access.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - FSM goes to IDLE; latency counter cleared.
  - Outputs: stall=0, rd_data=0, rd_valid=0, addr_err=0.
  - Memory contents are not cleared.
  - Reset asserted mid-load aborts the load: no rd_valid, rd_data=0.
- Request accepted when the FSM is in IDLE and valid_in=1.
- Store (mem_wr=1, mem_rd=0, addr<DEPTH):
  - Word written at the same rising edge.
  - No stall. rd_data is unchanged.
- Load (mem_rd=1, mem_wr=0, addr<DEPTH): FSM states IDLE -> BUSY -> IDLE.
  - Counter loaded with RD_LAT-1 on acceptance.
  - In BUSY, stall=1 combinationally. Counter decrements each cycle.
  - When counter reaches 0: rd_data updated, rd_valid=1 for one cycle, FSM returns to IDLE, stall drops that cycle.
  - Total latency: exactly RD_LAT cycles from the accepting edge to rd_valid high.
  - RD_LAT=1: no BUSY state; rd_valid the cycle after acceptance; stall never asserts.
  - Address is latched at acceptance. Inputs changing during BUSY are ignored.
- Illegal access (mem_addr>=DEPTH with mem_rd or mem_wr, or mem_rd=mem_wr=1):
  - No memory write; no load started.
  - addr_err pulses one cycle after acceptance.
  - rd_valid stays 0. Stall stays 0.
- valid_in=0: no access; mem_rd/mem_wr are ignored.
- Store-then-load to the same address on consecutive cycles returns the new data.
- Read-during-write cannot occur, because accesses are serialised by the FSM.
- pc_src (combinational):
  - Asserted only when valid_in=1, br_valid=1 and stall=0.
  - BNEQ: !Z. BEQ: Z. BGT: !Z&!N. BLT: N. BGTE: !N. BLTE: N|Z. BOVFL: V. BUNCOND: 1.
  - Otherwise pc_src=0.
  - A branch may coincide with a store; it is not allowed to coincide with a load (upstream guarantee).
- Width rules:
  - Address compare uses full AW bits.
  - Memory index uses the low clog2(DEPTH) bits after the range check.

Test Plan:
- Reset, then store 0xBEEF @ 0x0005, then load @ 0x0005 with RD_LAT=2 -> stall=1 for exactly 1 cycle; rd_valid pulses 2 cycles after acceptance; rd_data=0xBEEF.
- RD_LAT=1 back-to-back loads @ 3 then @ 4 (preloaded 0x1111/0x2222) -> rd_valid on consecutive cycles, data 0x1111 then 0x2222; stall never high.
- Load @ 0x0400 with DEPTH=1024 -> addr_err pulse one cycle; rd_valid=0; rd_data unchanged. Store @ 0xFFFF -> addr_err; the following load of 0x03FF is unchanged.
- mem_rd=mem_wr=1 @ 0x0010 -> addr_err pulse; location 0x0010 unchanged.
- Branch sweep, all 8 codes × all 8 flag combos with valid_in=br_valid=1 -> pc_src matches the truth table (e.g. BGT flags=000 -> 1, BGT flags=010 -> 0, BOVFL flags=001 -> 1); br_valid=0 -> pc_src=0.
- Assert rst_n=0 during BUSY with RD_LAT=4 -> stall=0 and rd_data=0 immediately; no rd_valid afterwards; memory contents preserved on a later load.
